seven_seg_scan_capture: RTL and testbench

Receive side of the multiplexed 7-segment display interface. The block samples the active-low anode and cathode lines of a time-multiplexed 4-digit display, waits for each digit slot to settle, and encodes each cathode pattern back to a hex nibble. When all four positions have been captured, it publishes a complete 16-bit frame. It sits between the display pins (or a looped-back display bus) and the self-check/readback logic.

---
 rtl/seven_seg_scan_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seven_seg_scan_capture.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/seven_seg_scan_capture.sv
// Receive side of a multiplexed 4-digit 7-segment display: samples anode/cathode pins,
// waits for each digit slot to settle, decodes it to a nibble and publishes whole frames.
module seven_seg_scan_capture #(
  parameter int STABLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] hex_out,
  output logic        frame_valid,
  output logic        pattern_err
);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(STABLE_CYCLES - 1);

  // Decode result: {is_digit, is_blank, nibble}
  function automatic logic [5:0] decode_seg(input logic [6:0] s);
    logic [5:0] r;
    case (s)
      7'b0000001: r = {2'b10, 4'h0};
      7'b1001111: r = {2'b10, 4'h1};
      7'b0010010: r = {2'b10, 4'h2};
      7'b0000110: r = {2'b10, 4'h3};
      7'b1001100: r = {2'b10, 4'h4};
      7'b0100100: r = {2'b10, 4'h5};
      7'b0100000: r = {2'b10, 4'h6};
      7'b0001111: r = {2'b10, 4'h7};
      7'b0000000: r = {2'b10, 4'h8};
      7'b0000100: r = {2'b10, 4'h9};
      7'b0001000: r = {2'b10, 4'hA};
      7'b1100000: r = {2'b10, 4'hB};
      7'b0110001: r = {2'b10, 4'hC};
      7'b1000010: r = {2'b10, 4'hD};
      7'b0110000: r = {2'b10, 4'hE};
      7'b0111000: r = {2'b10, 4'hF};
      7'b1111111: r = {2'b01, 4'h0};
      default:    r = {2'b00, 4'h0};
    endcase
    return r;
  endfunction

  function automatic logic one_cold(input logic [3:0] a);
    logic r;
    case (a)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: r = 1'b1;
      default:                            r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic [1:0] slot_index(input logic [3:0] a);
    logic [1:0] r;
    case (a)
      4'b1110: r = 2'd0;
      4'b1101: r = 2'd1;
      4'b1011: r = 2'd2;
      4'b0111: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  logic [3:0]       an_meta_q, an_sync_q, an_prev_q;
  logic [6:0]       seg_meta_q, seg_sync_q, seg_prev_q;
  state_t           state_q, state_d;
  logic [7:0]       cnt_q, cnt_d, cnt_inc_s;
  logic [3:0][3:0]  shadow_q, shadow_d;
  logic [3:0]       seen_q, seen_d, seen_next_s;
  logic [15:0]      hex_q, hex_d;
  logic             frame_valid_q, frame_valid_d;
  logic             pattern_err_q, pattern_err_d;
  logic             changed_s, valid_slot_s, capture_s;
  logic [5:0]       dec_s;
  logic [1:0]       idx_s;

  // Two-flop synchronizers plus a one-cycle history for change detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      an_meta_q  <= 4'hF;
      an_sync_q  <= 4'hF;
      an_prev_q  <= 4'hF;
      seg_meta_q <= 7'h7F;
      seg_sync_q <= 7'h7F;
      seg_prev_q <= 7'h7F;
    end else begin
      an_meta_q  <= an;
      an_sync_q  <= an_meta_q;
      an_prev_q  <= an_sync_q;
      seg_meta_q <= seg;
      seg_sync_q <= seg_meta_q;
      seg_prev_q <= seg_sync_q;
    end
  end

  assign changed_s    = ({an_sync_q, seg_sync_q} != {an_prev_q, seg_prev_q});
  assign valid_slot_s = one_cold(an_sync_q);
  assign cnt_inc_s    = (cnt_q == 8'hFF) ? 8'hFF : (cnt_q + 8'd1);
  assign dec_s        = decode_seg(seg_sync_q);
  assign idx_s        = slot_index(an_sync_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      ST_WAIT: begin
        cnt_d = 8'd0;
        if (valid_slot_s) begin
          state_d = ST_SETTLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_SETTLE: begin
        if (changed_s) begin
          cnt_d   = 8'd0;
          state_d = valid_slot_s ? ST_SETTLE : ST_WAIT;
        end else if (cnt_q >= CNT_LAST) begin
          capture_s = 1'b1;
          cnt_d     = cnt_inc_s;
          state_d   = ST_HOLD;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      ST_HOLD: begin
        if (changed_s) begin
          cnt_d   = 8'd0;
          state_d = valid_slot_s ? ST_SETTLE : ST_WAIT;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = ST_WAIT;
      end
    endcase
  end

  // A completed frame includes the nibble being captured this cycle.
  always_comb begin
    shadow_d      = shadow_q;
    seen_d        = seen_q;
    seen_next_s   = seen_q;
    hex_d         = hex_q;
    frame_valid_d = 1'b0;
    pattern_err_d = 1'b0;
    if (capture_s) begin
      if (dec_s[5]) begin
        shadow_d[idx_s] = dec_s[3:0];
        seen_next_s     = seen_q | (4'b0001 << idx_s);
        if (seen_next_s == 4'hF) begin
          hex_d         = shadow_d;
          frame_valid_d = 1'b1;
          seen_d        = 4'h0;
        end else begin
          seen_d = seen_next_s;
        end
      end else if (dec_s[4]) begin
        seen_d = seen_q;
      end else begin
        pattern_err_d = 1'b1;
      end
    end else begin
      seen_d = seen_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_WAIT;
      cnt_q         <= 8'd0;
      shadow_q      <= '0;
      seen_q        <= 4'h0;
      hex_q         <= 16'h0000;
      frame_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      seen_q        <= seen_d;
      hex_q         <= hex_d;
      frame_valid_q <= frame_valid_d;
      pattern_err_q <= pattern_err_d;
    end
  end

  assign hex_out     = hex_q;
  assign frame_valid = frame_valid_q;
  assign pattern_err = pattern_err_q;

endmodule

// File: tb/tb_seven_seg_scan_capture.sv
// Directed self-checking bench for seven_seg_scan_capture with STABLE_CYCLES = 4.
module tb_seven_seg_scan_capture;

  localparam int S = 4;

  localparam logic [3:0] P0 = 4'b1110;
  localparam logic [3:0] P1 = 4'b1101;
  localparam logic [3:0] P2 = 4'b1011;
  localparam logic [3:0] P3 = 4'b0111;

  localparam logic [6:0] PAT [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  an  = 4'hF;
  logic [6:0]  seg = 7'h7F;
  logic [15:0] hex_out;
  logic        frame_valid;
  logic        pattern_err;

  int total = 0;
  int passed = 0;
  int fv_cnt, pe_cnt, fv_at, both_cnt, hex_bad;
  logic [15:0] fv_hex, hex_prev;

  seven_seg_scan_capture #(.STABLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .an(an), .seg(seg),
    .hex_out(hex_out), .frame_valid(frame_valid), .pattern_err(pattern_err)
  );

  always #5 clk = ~clk;

  task automatic clear_counts();
    fv_cnt = 0; pe_cnt = 0; fv_at = -1; fv_hex = 16'h0000;
  endtask

  // Drive a pin state for n cycles, sampling outputs 1ns after each rising edge.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an = a; seg = s;
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      if (frame_valid) begin fv_cnt++; fv_hex = hex_out; fv_at = i; end
      if (pattern_err) pe_cnt++;
      if (frame_valid && pattern_err) both_cnt++;
      if (hex_out !== hex_prev && !frame_valid) hex_bad++;
      hex_prev = hex_out;
    end
  endtask

  task automatic test_reset();
    #3 rst = 1'b0;
    #20;
    total++; if (hex_out !== 16'h0000) $display("FAIL reset_hex: got %h want 0000", hex_out); else passed++;
    total++; if (frame_valid !== 1'b0) $display("FAIL reset_fv: got %b want 0", frame_valid); else passed++;
    total++; if (pattern_err !== 1'b0) $display("FAIL reset_pe: got %b want 0", pattern_err); else passed++;
    @(posedge clk); #1 rst = 1'b1;
    hex_prev = hex_out;
    both_cnt = 0; hex_bad = 0;
  endtask

  task automatic test_basic_frame();
    clear_counts();
    drive(P3, 7'b1001111, 10);
    drive(P2, 7'b0010010, 10);
    drive(P1, 7'b0000110, 10);
    total++; if (fv_cnt !== 0) $display("FAIL basic_early: got %0d frames want 0", fv_cnt); else passed++;
    drive(P0, 7'b1001100, 10);
    total++; if (fv_cnt !== 1) $display("FAIL basic_count: got %0d frames want 1", fv_cnt); else passed++;
    // Drive at edge 0 is first sampled at edge 1; pulse lands S+2 edges later.
    total++; if (fv_at !== S + 3) $display("FAIL basic_latency: got %0d want %0d", fv_at, S + 3); else passed++;
    total++; if (fv_hex !== 16'h1234) $display("FAIL basic_hex: got %h want 1234", fv_hex); else passed++;
    total++; if (hex_out !== 16'h1234) $display("FAIL basic_hold: got %h want 1234", hex_out); else passed++;
  endtask

  task automatic test_all_patterns();
    for (int p = 0; p < 16; p++) begin
      clear_counts();
      drive(P3, 7'b1001111, 8);
      drive(P2, 7'b0010010, 8);
      drive(P1, 7'b0000110, 8);
      drive(P0, PAT[p], 8);
      total++;
      if (fv_cnt !== 1 || fv_hex !== {12'h123, 4'(p)})
        $display("FAIL pattern_%0d: got %0d frames hex %h want 1 frame hex %h", p, fv_cnt, fv_hex, {12'h123, 4'(p)});
      else passed++;
    end
  endtask

  task automatic test_glitch();
    clear_counts();
    drive(P3, 7'b1001111, 8);
    drive(P2, 7'b0010010, 8);
    drive(P1, 7'b0000110, 8);
    drive(P0, 7'b0000000, S - 1);
    drive(P0, 7'b0000001, 8);
    total++; if (fv_cnt !== 1) $display("FAIL glitch_count: got %0d frames want 1", fv_cnt); else passed++;
    total++; if (fv_hex !== 16'h1230) $display("FAIL glitch_hex: got %h want 1230", fv_hex); else passed++;
  endtask

  task automatic test_invalid_blank_multi();
    clear_counts();
    drive(P3, 7'b1001111, 8);
    drive(P2, 7'b0010010, 8);
    drive(P1, 7'b0000110, 8);
    drive(P0, 7'b1010101, 10);
    total++; if (pe_cnt !== 1) $display("FAIL invalid_pe: got %0d pulses want 1", pe_cnt); else passed++;
    total++; if (fv_cnt !== 0) $display("FAIL invalid_fv: got %0d frames want 0", fv_cnt); else passed++;
    clear_counts();
    drive(P0, 7'b1111111, 10);
    total++; if (pe_cnt !== 0 || fv_cnt !== 0) $display("FAIL blank: got pe %0d fv %0d want 0 0", pe_cnt, fv_cnt); else passed++;
    drive(4'b1100, 7'b0000001, 10);
    total++; if (pe_cnt !== 0 || fv_cnt !== 0) $display("FAIL multi_anode: got pe %0d fv %0d want 0 0", pe_cnt, fv_cnt); else passed++;
    drive(P0, 7'b0100100, 8);
    total++; if (fv_cnt !== 1 || fv_hex !== 16'h1235) $display("FAIL after_invalid: got %0d frames hex %h want 1 1235", fv_cnt, fv_hex); else passed++;
  endtask

  task automatic test_overwrite();
    clear_counts();
    drive(P0, 7'b0001111, 8);
    drive(P1, 7'b1001111, 8);
    drive(P0, 7'b0001000, 8);
    total++; if (fv_cnt !== 0) $display("FAIL overwrite_early: got %0d frames want 0", fv_cnt); else passed++;
    drive(P2, 7'b0000110, 8);
    drive(P3, 7'b0010010, 8);
    total++; if (fv_cnt !== 1) $display("FAIL overwrite_count: got %0d frames want 1", fv_cnt); else passed++;
    total++; if (fv_hex !== 16'h231A) $display("FAIL overwrite_hex: got %h want 231a", fv_hex); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    clear_counts();
    drive(P0, 7'b1001111, 8);
    drive(P1, 7'b0010010, 8);
    an = 4'hF; seg = 7'h7F;
    #2 rst = 1'b0;
    #1;
    total++; if (hex_out !== 16'h0000) $display("FAIL rst_mid_hex: got %h want 0000", hex_out); else passed++;
    total++; if (frame_valid !== 1'b0 || pattern_err !== 1'b0) $display("FAIL rst_mid_pulses: got fv %b pe %b want 0 0", frame_valid, pattern_err); else passed++;
    @(posedge clk); #1;
    total++; if (dut.cnt_q !== 8'd0) $display("FAIL rst_mid_cnt: got %0d want 0", dut.cnt_q); else passed++;
    rst = 1'b1;
    hex_prev = hex_out;
    drive(P2, 7'b0000110, 8);
    drive(P3, 7'b1001100, 8);
    total++; if (fv_cnt !== 0) $display("FAIL rst_discard: got %0d frames want 0", fv_cnt); else passed++;
    drive(P0, 7'b0100100, 8);
    drive(P1, 7'b0100000, 8);
    total++; if (fv_cnt !== 1) $display("FAIL rst_refill_count: got %0d frames want 1", fv_cnt); else passed++;
    total++; if (fv_hex !== 16'h4365) $display("FAIL rst_refill_hex: got %h want 4365", fv_hex); else passed++;
  endtask

  task automatic test_long_dwell();
    clear_counts();
    drive(P1, 7'b1010101, 300);
    total++; if (pe_cnt !== 1) $display("FAIL dwell_pe: got %0d pulses want 1", pe_cnt); else passed++;
    total++; if (dut.cnt_q !== 8'hFF) $display("FAIL dwell_cnt: got %0d want 255", dut.cnt_q); else passed++;
  endtask

  task automatic test_global();
    total++; if (both_cnt !== 0) $display("FAIL pulse_overlap: got %0d cycles want 0", both_cnt); else passed++;
    total++; if (hex_bad !== 0) $display("FAIL hex_unstable: got %0d changes without frame_valid want 0", hex_bad); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_all_patterns();
    test_glitch();
    test_invalid_blank_multi();
    test_overwrite();
    test_reset_mid_frame();
    test_long_dwell();
    test_global();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
